phase_sequencer: RTL

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 92 +++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - one-hot execution phase sequencer with step, halt and retire counting
module phase_sequencer #(
    parameter int NPHASE = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              early_done,
    input  logic              hlt_req,
    input  logic              step_mode,
    input  logic              step_req,
    output logic [NPHASE-1:0] phase,
    output logic              running,
    output logic              halted,
    output logic              retire,
    output logic [CNT_W-1:0]  instr_cnt
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_STEP_WAIT = 2'd2,
        S_HALT      = 2'd3
    } state_t;

    localparam logic [NPHASE-1:0] PH_FIRST = NPHASE'(1);
    localparam logic [NPHASE-1:0] PH_NONE  = '0;

    state_t            state, state_nxt;
    logic [NPHASE-1:0] phase_nxt;

    // Stall dominates; early_done only counts once past the first phase.
    assign retire  = (state == S_RUN) && !stall &&
                     (phase[NPHASE-1] || (early_done && !phase[0]));
    assign running = (state == S_RUN);
    assign halted  = (state == S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            phase     <= PH_NONE;
            instr_cnt <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            if (retire) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nxt = S_RUN;
                    phase_nxt = PH_FIRST;
                end
            end
            S_RUN: begin
                if (retire) begin
                    if (hlt_req) begin
                        state_nxt = S_HALT;
                        phase_nxt = PH_NONE;
                    end else if (step_mode) begin
                        state_nxt = S_STEP_WAIT;
                        phase_nxt = PH_NONE;
                    end else begin
                        phase_nxt = PH_FIRST;
                    end
                end else if (!stall) begin
                    phase_nxt = phase << 1;
                end
            end
            S_STEP_WAIT: begin
                if (step_req || !step_mode) begin
                    state_nxt = S_RUN;
                    phase_nxt = PH_FIRST;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                phase_nxt = PH_NONE;
            end
        endcase
    end

endmodule
